// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: serves 32-bit words to the core from a byte-wide
// synchronous memory through a one-entry word buffer.
module inst_fetch_bridge #(
    parameter int MEM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rom_ce_i,
    input  logic [31:0]               rom_addr_i,
    output logic [31:0]               rom_data_o,
    output logic                      stallreq_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_a_o,
    output logic                      mem_re_o,
    input  logic [7:0]                mem_din_i
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t                    r_state;
    logic [31:0]               r_buf_data;
    logic [29:0]               r_buf_tag;
    logic                      r_buf_valid;
    logic [29:0]               r_req_tag;
    logic [2:0]                r_iss;
    logic [2:0]                r_cap;
    logic [23:0]               r_asm;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_a;
    logic                      r_mem_re;

    logic [29:0]               w_word;
    logic                      w_hit;
    logic                      w_miss;
    logic                      w_redirect;
    logic                      w_start;
    logic [MEM_ADDR_WIDTH-1:0] w_new_base;
    logic [MEM_ADDR_WIDTH-1:0] w_base;
    logic                      w_unused;

    assign w_word     = rom_addr_i[31:2];
    assign w_unused   = ^rom_addr_i[1:0];
    assign w_hit      = rom_ce_i & r_buf_valid & (r_buf_tag == w_word);
    assign w_miss     = rom_ce_i & ~w_hit;
    assign w_redirect = rom_ce_i & (w_word != r_req_tag);
    assign w_start    = ((r_state == IDLE) & w_miss)
                      | ((r_state == FETCH) & w_redirect);
    assign w_new_base = MEM_ADDR_WIDTH'({w_word, 2'b00});
    assign w_base     = MEM_ADDR_WIDTH'({r_req_tag, 2'b00});

    assign rom_data_o = w_hit ? r_buf_data : 32'h0;
    assign stallreq_o = w_miss;
    assign mem_a_o    = r_mem_a;
    assign mem_re_o   = r_mem_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_buf_data  <= 32'h0;
            r_buf_tag   <= 30'h0;
            r_buf_valid <= 1'b0;
            r_req_tag   <= 30'h0;
            r_iss       <= 3'd0;
            r_cap       <= 3'd0;
            r_asm       <= 24'h0;
            r_mem_a     <= '0;
            r_mem_re    <= 1'b0;
        end else if (w_start) begin
            // A redirect discards any partial fill; the buffer is untouched.
            r_req_tag <= w_word;
            r_mem_a   <= w_new_base;
            r_mem_re  <= 1'b1;
            r_iss     <= 3'd1;
            r_cap     <= 3'd0;
            r_state   <= FETCH;
        end else if (r_state == FETCH) begin
            if (r_iss < 3'd4) begin
                r_mem_a <= w_base + MEM_ADDR_WIDTH'(r_iss);
                r_iss   <= r_iss + 3'd1;
            end else begin
                r_mem_re <= 1'b0;
            end
            // Read data trails the address by one cycle.
            if (r_iss >= 3'd2) begin
                r_cap <= r_cap + 3'd1;
                case (r_cap)
                    3'd0: r_asm[7:0]   <= mem_din_i;
                    3'd1: r_asm[15:8]  <= mem_din_i;
                    3'd2: r_asm[23:16] <= mem_din_i;
                    default: begin
                        r_buf_data  <= {mem_din_i, r_asm};
                        r_buf_tag   <= r_req_tag;
                        r_buf_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Scoreboard bench for inst_fetch_bridge: directed fetch sequences, a byte
// memory model, and a monitor that checks each newly delivered word.
module tb_inst_fetch_bridge;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        stallreq_o;
    logic [16:0] mem_a_o;
    logic        mem_re_o;
    logic [7:0]  mem_din_i;

    logic [7:0]  mem [0:(1<<17)-1];
    exp_t        sb[$];
    int          n_chk;
    int          n_pass;

    inst_fetch_bridge #(.MEM_ADDR_WIDTH(17)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .stallreq_o (stallreq_o),
        .mem_a_o    (mem_a_o),
        .mem_re_o   (mem_re_o),
        .mem_din_i  (mem_din_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re_o) mem_din_i <= mem[mem_a_o];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: a delivery event is the first non-stalled fetch of a word.
    logic        mon_prev_ok;
    logic [29:0] mon_prev_word;
    always @(negedge clk) begin
        logic ok;
        exp_t e;
        if (rst) begin
            mon_prev_ok = 1'b0;
        end else begin
            ok = rom_ce_i && !stallreq_o;
            if (ok && (!mon_prev_ok || rom_addr_i[31:2] != mon_prev_word)) begin
                if (sb.size() == 0) begin
                    check("mon_unexpected_word", rom_addr_i, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("mon_addr", rom_addr_i, e.addr);
                    check("mon_data", rom_data_o, e.data);
                end
            end
            mon_prev_ok   = ok;
            mon_prev_word = rom_addr_i[31:2];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Counts stalled cycles from the current one; checks the byte address walk.
    task automatic wait_fill(input string name, input logic [16:0] base);
        int n;
        logic [16:0] a [0:7];
        n = 0;
        @(negedge clk);
        while (stallreq_o && n < 20) begin
            if (n < 8) a[n] = mem_a_o;
            n++;
            @(negedge clk);
        end
        check({name, "_stalls"}, 32'(n), 32'd6);
        for (int i = 1; i <= 4; i++) begin
            if (n > i) check({name, "_mem_a"}, 32'(a[i]), 32'(base + 17'(i - 1)));
        end
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]     = w[7:0];
        mem[a + 1] = w[15:8];
        mem[a + 2] = w[23:16];
        mem[a + 3] = w[31:24];
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        mon_prev_ok = 1'b0;
        mon_prev_word = 30'h0;
        for (int i = 0; i < (1 << 17); i++) mem[i] = 8'h00;
        put_word(0,  32'h0010_0513);
        put_word(4,  32'h0020_0593);
        put_word(8,  32'h8000_0537);
        put_word(16, 32'h0031_0613);
        put_word(24, 32'h00B5_0633);
        put_word(32, 32'h0000_006F);

        rst = 1'b1;
        rom_ce_i = 1'b0;
        rom_addr_i = 32'h0;
        tick();
        tick();
        check("rst_data", rom_data_o, 32'h0);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_mem_a", 32'(mem_a_o), 32'd0);
        check("rst_mem_re", 32'(mem_re_o), 32'd0);
        rst = 1'b0;

        // First fetch after reset
        tick();
        rom_ce_i = 1'b1;
        rom_addr_i = 32'h0;
        expect_word(32'h0, 32'h0010_0513);
        wait_fill("first", 17'h0);

        // Hits: same word, then a misaligned pc in the same word
        tick();
        check("hit_data", rom_data_o, 32'h0010_0513);
        check("hit_stall", 32'(stallreq_o), 32'd0);
        check("hit_no_re", 32'(mem_re_o), 32'd0);
        tick();
        rom_addr_i = 32'h2;
        #1;
        check("hit2_data", rom_data_o, 32'h0010_0513);
        check("hit2_stall", 32'(stallreq_o), 32'd0);
        check("hit2_no_re", 32'(mem_re_o), 32'd0);

        // Sequential miss; word 0 is evicted
        tick();
        rom_addr_i = 32'h4;
        expect_word(32'h4, 32'h0020_0593);
        wait_fill("seq", 17'h4);
        tick();
        rom_addr_i = 32'h0;
        #1;
        check("evict_miss", 32'(stallreq_o), 32'd1);
        check("evict_data", rom_data_o, 32'h0);
        expect_word(32'h0, 32'h0010_0513);
        wait_fill("refill", 17'h0);

        // Redirect at C3 of a fill of word 8
        tick();
        rom_addr_i = 32'h8;
        tick();
        tick();
        tick();
        rom_addr_i = 32'h10;
        expect_word(32'h10, 32'h0031_0613);
        wait_fill("redir", 17'h10);
        tick();
        rom_addr_i = 32'h8;
        #1;
        check("redir_8_absent", 32'(stallreq_o), 32'd1);

        // Reset at C3 of that miss
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_mem_a", 32'(mem_a_o), 32'd0);
        check("midrst_mem_re", 32'(mem_re_o), 32'd0);
        rst = 1'b0;
        rom_addr_i = 32'h10;
        #1;
        check("midrst_buf_inval", 32'(stallreq_o), 32'd1);
        expect_word(32'h10, 32'h0031_0613);
        wait_fill("postrst", 17'h10);

        // rom_ce_i low from C2 to C6; fill still lands
        tick();
        rom_addr_i = 32'h18;
        expect_word(32'h18, 32'h00B5_0633);
        tick();
        tick();
        rom_ce_i = 1'b0;
        #1;
        check("ce_low_stall", 32'(stallreq_o), 32'd0);
        check("ce_low_data", rom_data_o, 32'h0);
        tick();
        check("ce_low_stall_c3", 32'(stallreq_o), 32'd0);
        tick();
        tick();
        tick();
        tick();
        rom_ce_i = 1'b1;
        #1;
        check("ce_back_stall", 32'(stallreq_o), 32'd0);
        check("ce_back_data", rom_data_o, 32'h00B5_0633);

        // Upper pc bits beyond the memory width are dropped
        tick();
        rom_addr_i = 32'h0002_0020;
        expect_word(32'h0002_0020, 32'h0000_006F);
        wait_fill("wrap", 17'h20);

        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
